// File: rtl/input_debouncer_pkg.sv
// Shared types and constants for the two-channel switch debouncer.
package input_debouncer_pkg;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

    localparam int STABLE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounced switch channel: two-flop synchronizer, stability counter,
// two-state FSM and registered rise/fall pulses.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    db_state_e     st;
    db_state_e     st_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;
    logic          rise_nxt;
    logic          fall_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= DB_STABLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            st    <= st_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // In STABLE the counter is zero, so CNT_LAST==0 flips on the first mismatch.
    always_comb begin
        st_nxt    = DB_STABLE;
        cnt_nxt   = '0;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = sync2;
                rise_nxt  = sync2;
                fall_nxt  = ~sync2;
            end else begin
                st_nxt  = DB_PENDING;
                cnt_nxt = (st == DB_PENDING) ? cnt + CW'(1) : CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Two independent debounce channels producing clean gate operands a and b.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_a_raw,
    input  logic sw_b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw_a_raw),
        .level (a),
        .rise  (a_rise),
        .fall  (a_fall)
    );

    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw_b_raw),
        .level (b),
        .rise  (b_rise),
        .fall  (b_fall)
    );

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios with literal timing checks plus
// a per-cycle comparison against a history-window model of the debounce rule.
module tb_input_debouncer;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_a_raw;
    logic sw_b_raw;
    logic a, b, a_rise, a_fall, b_rise, b_fall;

    int n_checks = 0;
    int n_err    = 0;
    int cnt_a_rise = 0, cnt_a_fall = 0, cnt_b_rise = 0, cnt_b_fall = 0;

    input_debouncer #(.STABLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_a_raw (sw_a_raw),
        .sw_b_raw (sw_b_raw),
        .a        (a),
        .b        (b),
        .a_rise   (a_rise),
        .a_fall   (a_fall),
        .b_rise   (b_rise),
        .b_fall   (b_fall)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Model: output of a channel flips once the last S synchronized samples
    // seen since reset all disagree with it. Bit 0 = channel A, bit 1 = B.
    logic [1:0] m_s1 = '0, m_s2 = '0, m_out = '0, m_rise = '0, m_fall = '0;
    logic [1:0] hist[$];

    always @(posedge clk or negedge rst_n) begin
        int diff;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > S) void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < 2; ch++) begin
                diff = 0;
                foreach (hist[i]) if (hist[i][ch] != m_out[ch]) diff++;
                if (hist.size() == S && diff == S) begin
                    m_out[ch]  = ~m_out[ch];
                    m_rise[ch] = m_out[ch];
                    m_fall[ch] = ~m_out[ch];
                end
            end
            m_s2 = m_s1;
            m_s1 = {sw_b_raw, sw_a_raw};
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every cycle, DUT outputs against the model
    always @(negedge clk) begin
        check("model_cmp",
              {2'b00, b_fall, b_rise, b, a_fall, a_rise, a},
              {2'b00, m_fall[1], m_rise[1], m_out[1], m_fall[0], m_rise[0], m_out[0]});
        if (a_rise) cnt_a_rise++;
        if (a_fall) cnt_a_fall++;
        if (b_rise) cnt_b_rise++;
        if (b_fall) cnt_b_fall++;
    end

    // driver helpers: tick() leaves time 2 units after the n-th rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        cnt_a_rise = 0; cnt_a_fall = 0; cnt_b_rise = 0; cnt_b_fall = 0;
    endtask

    initial begin
        rst_n = 1'b0; sw_a_raw = 1'b1; sw_b_raw = 1'b1;

        // reset held with both raw inputs high
        tick(3);
        check("reset_outputs", {2'b00, a, b, a_rise, a_fall, b_rise, b_fall}, 8'h00);
        clear_counts();
        rst_n = 1'b1;
        tick(5);
        check("reset_edge4", {6'b0, a, b}, 8'b00);
        tick(1);
        check("reset_edge5", {4'b0, a, b, a_rise, b_rise}, 8'b1111);
        tick(1);
        check("reset_edge6", {4'b0, a, b, a_rise, b_rise}, 8'b1100);

        // settle both low, then clean A transition
        sw_a_raw = 1'b0; sw_b_raw = 1'b0;
        tick(8);
        clear_counts();
        sw_a_raw = 1'b1;
        tick(5);
        check("clean_edge4", {7'b0, a}, 8'd0);
        tick(1);
        check("clean_edge5", {4'b0, a, a_rise, a_fall, b}, 8'b1100);
        tick(1);
        check("clean_edge6", {7'b0, a_rise}, 8'd0);
        tick(3);
        check("clean_counts", {cnt_a_rise[1:0], cnt_a_fall[1:0], cnt_b_rise[1:0], cnt_b_fall[1:0]},
              8'b01_00_00_00);

        // bounce rejection on A
        sw_a_raw = 1'b0;
        tick(8);
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            sw_a_raw = (i % 2 == 0);
            tick(3);
        end
        sw_a_raw = 1'b1;
        tick(5);
        check("bounce_edge4", {7'b0, a}, 8'd0);
        tick(1);
        check("bounce_edge5", {6'b0, a, a_rise}, 8'b11);
        tick(3);
        check("bounce_counts", {4'b0, cnt_a_rise[1:0], cnt_a_fall[1:0]}, 8'b0100);

        // simultaneous: A rises while B falls
        sw_a_raw = 1'b0; sw_b_raw = 1'b1;
        tick(8);
        check("simul_pre", {6'b0, a, b}, 8'b01);
        sw_a_raw = 1'b1; sw_b_raw = 1'b0;
        tick(5);
        check("simul_edge4", {6'b0, a, b}, 8'b01);
        tick(1);
        check("simul_edge5", {4'b0, a, b, a_rise, b_fall}, 8'b1011);
        tick(1);
        check("simul_edge6", {6'b0, a_rise, b_fall}, 8'b00);

        // boundary: 3-cycle glitch rejected, 4-cycle glitch accepted
        sw_a_raw = 1'b0; sw_b_raw = 1'b0;
        tick(8);
        clear_counts();
        sw_a_raw = 1'b1;
        tick(3);
        sw_a_raw = 1'b0;
        tick(10);
        check("glitch3", {6'b0, a, cnt_a_rise[0]}, 8'b00);
        sw_a_raw = 1'b1;
        tick(4);
        sw_a_raw = 1'b0;
        tick(1);
        check("glitch4_edge4", {7'b0, a}, 8'd0);
        tick(1);
        check("glitch4_edge5", {6'b0, a, a_rise}, 8'b11);
        tick(3);
        check("glitch4_edge8", {7'b0, a}, 8'd1);
        tick(1);
        check("glitch4_back", {6'b0, a, a_fall}, 8'b01);

        // reset mid-pending on B
        tick(4);
        clear_counts();
        sw_b_raw = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("midrst_low", {6'b0, b, b_rise}, 8'b00);
        rst_n = 1'b1;
        tick(5);
        check("midrst_edge4", {6'b0, b, cnt_b_rise[0]}, 8'b00);
        tick(1);
        check("midrst_edge5", {6'b0, b, b_rise}, 8'b11);
        tick(2);
        check("midrst_counts", {4'b0, cnt_b_rise[1:0], cnt_b_fall[1:0]}, 8'b0100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
